// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the Mr. Kabuki graphics ROM path: default ROM
// geometry and the ROM cache controller state encoding.
package jtmx5k_pkg;

  localparam int MX5K_ROM_AW = 18;
  localparam int MX5K_ROM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } mx5k_cache_state_e;

endpackage

// File: rtl/jtmx5k_romcache_tags.sv
// Tag/valid/data array of the graphics ROM cache. Fully associative lookup
// with a parallel compare against every valid entry, one write port, and a
// flush that drops every valid bit in a single cycle.
module jtmx5k_romcache_tags
  import jtmx5k_pkg::*;
#(
  parameter int AW      = MX5K_ROM_AW,
  parameter int DW      = MX5K_ROM_DW,
  parameter int ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [AW-1:0]              lk_addr,
  output logic                       hit,
  output logic [DW-1:0]              hit_data,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [AW-1:0]              wr_tag,
  input  logic [DW-1:0]              wr_data
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [AW-1:0]      tag_q  [ENTRIES];
  logic [AW-1:0]      tag_d  [ENTRIES];
  logic [DW-1:0]      data_q [ENTRIES];
  logic [DW-1:0]      data_d [ENTRIES];

  // Parallel compare; tags are unique so OR-ing the matching data is a mux.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == lk_addr)) begin
        hit      = 1'b1;
        hit_data = hit_data | data_q[i];
      end
    end
  end

  // Entry update: write port first, flush overrides every valid bit.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (flush) valid_d = '0;
  end

  // Valid bits are the only state that must come out of reset cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data storage; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/jtmx5k_gfx_romcache.sv
// Read cache between the first graphics chip ROM port and its SDRAM slot.
// One outstanding SDRAM request, round-robin replacement, jtframe-style ok.
// Build option: define JTMX5K_ROMCACHE_STATS_EN to get a saturating hit
// counter on `hits`; otherwise `hits` reads 0 and no counter is built.
module jtmx5k_gfx_romcache
  import jtmx5k_pkg::*;
#(
  parameter int AW      = MX5K_ROM_AW,
  parameter int DW      = MX5K_ROM_DW,
  parameter int ENTRIES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cl_cs,
  input  logic [AW-1:0] cl_addr,
  output logic [DW-1:0] cl_data,
  output logic          cl_ok,
  output logic          sd_cs,
  output logic [AW-1:0] sd_addr,
  input  logic [DW-1:0] sd_data,
  input  logic          sd_ok,
  output logic [15:0]   hits
);

  localparam int IW = $clog2(ENTRIES);

  mx5k_cache_state_e state_q, state_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          drop_q, drop_d;
  logic [IW-1:0] victim_q, victim_d;

  logic          tag_hit;
  logic [DW-1:0] tag_data;
  logic          lookup, miss_start, hit_load, sd_load, fill_we;

  assign cl_ok   = cl_cs & out_valid_q & (out_addr_q == cl_addr);
  assign cl_data = out_data_q;
  assign sd_addr = req_addr_q;

  assign lookup     = (state_q == IDLE) & cl_cs & ~cl_ok;
  assign miss_start = lookup & ~tag_hit;
  assign hit_load   = lookup & tag_hit & ~flush;
  // The output register is loaded on sd_ok so cl_ok rises with sd_cs falling;
  // the cache entry itself is written one cycle later in FILL.
  assign sd_load    = (state_q == REQ) & sd_ok & ~drop_q & ~flush;
  assign fill_we    = (state_q == FILL) & ~drop_q & ~flush;

  jtmx5k_romcache_tags #(
    .AW      (AW),
    .DW      (DW),
    .ENTRIES (ENTRIES)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .lk_addr  (cl_addr),
    .hit      (tag_hit),
    .hit_data (tag_data),
    .wr_en    (fill_we),
    .wr_idx   (victim_q),
    .wr_tag   (req_addr_q),
    .wr_data  (out_data_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a request can never be abandoned once issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_start) state_d = REQ;
      REQ:     if (sd_ok) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: SDRAM request is a level held for the whole REQ state.
  always_comb begin
    sd_cs = (state_q == REQ);
  end

  // Request address, output register, discard flag and victim pointer.
  always_comb begin
    req_addr_d  = req_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    victim_d    = victim_q;
    if (miss_start) begin
      req_addr_d = cl_addr;
      drop_d     = 1'b0;
    end
    if (state_q == REQ) drop_d = drop_q | flush;
    if (hit_load) begin
      out_addr_d  = cl_addr;
      out_data_d  = tag_data;
      out_valid_d = 1'b1;
    end
    if (sd_load) begin
      out_addr_d  = req_addr_q;
      out_data_d  = sd_data;
      out_valid_d = 1'b1;
    end
    if (fill_we) victim_d = victim_q + 1'b1;
    if (flush) out_valid_d = 1'b0;
  end

  // Datapath registers; cleared so cl_data and sd_addr read 0 from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      victim_q    <= '0;
    end else begin
      req_addr_q  <= req_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      victim_q    <= victim_d;
    end
  end

`ifdef JTMX5K_ROMCACHE_STATS_EN
  logic [15:0] hits_q, hits_d;

  // Hit counter saturates; only reset clears it, flush leaves it alone.
  always_comb begin
    hits_d = hits_q;
    if (hit_load && (hits_q != 16'hFFFF)) hits_d = hits_q + 16'd1;
  end

  // Hit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hits_q <= '0;
    else        hits_q <= hits_d;
  end

  assign hits = hits_q;
`else
  assign hits = '0;
`endif

endmodule

// File: tb/tb_jtmx5k_gfx_romcache.sv
// Bench for jtmx5k_gfx_romcache: directed corner cases plus a randomized
// request stream, checked against a FIFO-replacement cache model.
module tb_jtmx5k_gfx_romcache;

  localparam int AW      = 18;
  localparam int DW      = 16;
  localparam int ENTRIES = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          cl_cs = 1'b0;
  logic [AW-1:0] cl_addr = '0;
  logic [DW-1:0] cl_data;
  logic          cl_ok;
  logic          sd_cs;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_data = '0;
  logic          sd_ok = 1'b0;
  logic [15:0]   hits;

  jtmx5k_gfx_romcache #(.AW(AW), .DW(DW), .ENTRIES(ENTRIES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .cl_cs   (cl_cs),
    .cl_addr (cl_addr),
    .cl_data (cl_data),
    .cl_ok   (cl_ok),
    .sd_cs   (sd_cs),
    .sd_addr (sd_addr),
    .sd_data (sd_data),
    .sd_ok   (sd_ok),
    .hits    (hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cached addresses in fill order, last delivered address.
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_out_addr = '0;
  bit            m_out_vld  = 1'b0;
  int            m_hits     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {12'd0, 2'd0, a[17:16]} ^ {a[7:0], 8'd0};
  endfunction

  function automatic bit m_has(input logic [AW-1:0] a);
    foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_insert(input logic [AW-1:0] a);
    if (m_q.size() == ENTRIES) void'(m_q.pop_front());
    m_q.push_back(a);
  endfunction

  function automatic void m_clear();
    m_q.delete();
    m_out_vld = 1'b0;
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef JTMX5K_ROMCACHE_STATS_EN
    return (m_hits > 65535) ? 32'd65535 : 32'(m_hits);
`else
    return 32'd0;
`endif
  endfunction

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One client transaction; the model decides whether it is already
  // presented, a cache hit or a miss requiring an SDRAM fetch.
  task automatic do_req(input logic [AW-1:0] a);
    bit same, hit;
    int lat;
    same = m_out_vld && (m_out_addr == a);
    hit  = m_has(a);
    cyc(); cl_cs = 1'b1; cl_addr = a; #3;
    if (same) begin
      check_eq("same_ok", 32'(cl_ok), 32'd1);
      check_eq("same_data", 32'(cl_data), 32'(mem(a)));
      check_eq("same_sd_cs", 32'(sd_cs), 32'd0);
    end else begin
      check_eq("lookup_ok", 32'(cl_ok), 32'd0);
      if (hit) begin
        cyc(); #3;
        m_hits++;
        check_eq("hit_ok", 32'(cl_ok), 32'd1);
        check_eq("hit_data", 32'(cl_data), 32'(mem(a)));
        check_eq("hit_sd_cs", 32'(sd_cs), 32'd0);
      end else begin
        cyc(); #3;
        check_eq("miss_sd_cs", 32'(sd_cs), 32'd1);
        check_eq("miss_sd_addr", 32'(sd_addr), 32'(a));
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          cyc(); #3;
          check_eq("wait_sd_cs", 32'(sd_cs), 32'd1);
          check_eq("wait_sd_addr", 32'(sd_addr), 32'(a));
        end
        cyc(); sd_ok = 1'b1; sd_data = mem(a);
        cyc(); sd_ok = 1'b0; sd_data = DW'($urandom); #3;
        check_eq("fill_sd_cs", 32'(sd_cs), 32'd0);
        check_eq("fill_ok", 32'(cl_ok), 32'd1);
        check_eq("fill_data", 32'(cl_data), 32'(mem(a)));
        m_insert(a);
      end
      m_out_addr = a;
      m_out_vld  = 1'b1;
    end
    check_eq("hits", 32'(hits), exp_hits());
  endtask

  // Client idle; stray sd_ok pulses must be ignored.
  task automatic gap(input int n);
    repeat (n) begin
      cyc(); cl_cs = 1'b0; sd_ok = ($urandom_range(0, 3) == 0); sd_data = DW'($urandom); #3;
      check_eq("gap_ok", 32'(cl_ok), 32'd0);
      check_eq("gap_sd_cs", 32'(sd_cs), 32'd0);
    end
    cyc(); sd_ok = 1'b0;
  endtask

  task automatic do_flush();
    cyc(); cl_cs = 1'b0; flush = 1'b1;
    cyc(); flush = 1'b0;
    m_clear();
  endtask

  logic [AW-1:0] pool[6];

  initial begin
    pool[0] = 18'h00123; pool[1] = 18'h00456; pool[2] = 18'h3FFFF;
    pool[3] = 18'h10000; pool[4] = 18'h00010; pool[5] = 18'h2ABCD;

    // Reset state, with the client already requesting.
    cl_cs = 1'b1; cl_addr = 18'h00123;
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst_cl_ok", 32'(cl_ok), 32'd0);
    check_eq("rst_cl_data", 32'(cl_data), 32'd0);
    check_eq("rst_sd_cs", 32'(sd_cs), 32'd0);
    check_eq("rst_sd_addr", 32'(sd_addr), 32'd0);
    check_eq("rst_hits", 32'(hits), 32'd0);
    cl_cs = 1'b0;
    cyc(); rst_n = 1'b1;

    // Cold miss, then a hit after another address.
    do_req(18'h00123);
    do_req(18'h00456);
    do_req(18'h00123);

    // Eviction: five distinct fills, first misses again, fifth still hits.
    do_flush();
    for (int i = 0; i < 5; i++) do_req(AW'(18'h00100 + i));
    do_req(18'h00100);
    do_req(18'h00104);

    // Address change while the fetch is outstanding.
    do_flush();
    cyc(); cl_cs = 1'b1; cl_addr = 18'h00010; #3;
    cyc(); #3;
    check_eq("mid_sd_cs", 32'(sd_cs), 32'd1);
    cyc(); cl_addr = 18'h00020; #3;
    check_eq("mid_sd_addr", 32'(sd_addr), 32'h10);
    check_eq("mid_ok", 32'(cl_ok), 32'd0);
    cyc(); sd_ok = 1'b1; sd_data = mem(18'h00010);
    cyc(); sd_ok = 1'b0; #3;
    check_eq("mid_fill_ok", 32'(cl_ok), 32'd0);
    check_eq("mid_fill_sd_cs", 32'(sd_cs), 32'd0);
    m_insert(18'h00010); m_out_addr = 18'h00010; m_out_vld = 1'b1;
    cyc(); #3;
    check_eq("mid_idle_sd_cs", 32'(sd_cs), 32'd0);
    cyc(); #3;
    check_eq("mid_new_sd_cs", 32'(sd_cs), 32'd1);
    check_eq("mid_new_sd_addr", 32'(sd_addr), 32'h20);
    cyc(); sd_ok = 1'b1; sd_data = mem(18'h00020);
    cyc(); sd_ok = 1'b0; #3;
    check_eq("mid_new_ok", 32'(cl_ok), 32'd1);
    check_eq("mid_new_data", 32'(cl_data), 32'(mem(18'h00020)));
    m_insert(18'h00020); m_out_addr = 18'h00020;
    do_req(18'h00010);

    // Flush while the request is outstanding: fill is discarded.
    do_flush();
    cyc(); cl_cs = 1'b1; cl_addr = 18'h3ABCD; #3;
    cyc(); #3;
    check_eq("flq_sd_cs", 32'(sd_cs), 32'd1);
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0; #3;
    check_eq("flq_sd_cs_held", 32'(sd_cs), 32'd1);
    cyc(); sd_ok = 1'b1; sd_data = mem(18'h3ABCD);
    cyc(); sd_ok = 1'b0; #3;
    check_eq("flq_no_ok", 32'(cl_ok), 32'd0);
    m_clear();
    gap(1);
    do_req(18'h3ABCD);

    // Flush in the same cycle as the cache write.
    do_flush();
    cyc(); cl_cs = 1'b1; cl_addr = 18'h20F0F;
    cyc(); sd_ok = 1'b1; sd_data = mem(18'h20F0F);
    cyc(); sd_ok = 1'b0; flush = 1'b1; #3;
    check_eq("flf_ok_fill", 32'(cl_ok), 32'd1);
    cyc(); flush = 1'b0; cl_cs = 1'b0; #3;
    m_clear();
    gap(1);
    do_req(18'h20F0F);

    // Reset asserted mid-fetch.
    do_req(18'h00456);
    do_req(18'h00457);
    cyc(); cl_cs = 1'b1; cl_addr = 18'h01111; #3;
    cyc(); #3;
    check_eq("rmid_sd_cs_before", 32'(sd_cs), 32'd1);
    rst_n = 1'b0; #1;
    check_eq("rmid_sd_cs", 32'(sd_cs), 32'd0);
    check_eq("rmid_cl_ok", 32'(cl_ok), 32'd0);
    check_eq("rmid_hits", 32'(hits), 32'd0);
    cyc(); cl_cs = 1'b0;
    cyc(); rst_n = 1'b1;
    m_clear(); m_hits = 0;
    do_req(18'h00456);

    // Randomized request stream.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      do_req(pool[$urandom_range(0, 5)]);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
